// File: rtl/gin_tag_sender.sv
// GIN tag/valid/ready transmitter: fetches cmd_len source beats and drives them with the command's tags.
// Optional no-receiver drop timeout is compiled in with `define GIN_TX_TIMEOUT_EN.
`ifndef XID_BITS
`define XID_BITS 4
`endif
`ifndef YID_BITS
`define YID_BITS 4
`endif

module gin_tag_sender #(
   parameter int XID_SIZE  = `XID_BITS,
   parameter int YID_SIZE  = `YID_BITS,
   parameter int DATA_SIZE = 32,
   parameter int LEN_BITS  = 8,
   parameter int TIMEOUT   = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [YID_SIZE-1:0]  cmd_row_tag,
   input  logic [XID_SIZE-1:0]  cmd_col_tag,
   input  logic [LEN_BITS-1:0]  cmd_len,
   input  logic                 src_valid,
   output logic                 src_ready,
   input  logic [DATA_SIZE-1:0] src_data,
   output logic                 gin_valid,
   input  logic                 gin_ready,
   output logic [YID_SIZE-1:0]  gin_row_tag,
   output logic [XID_SIZE-1:0]  gin_col_tag,
   output logic [DATA_SIZE-1:0] gin_data,
   output logic                 busy,
   output logic                 timeout_err,
   output logic [15:0]          drop_cnt
);

   // state | meaning
   // IDLE  | waiting for a command; cmd_ready high
   // XFER  | fetching beats from the source into the output stage
   // DRAIN | last beat fetched; waiting for the output stage to empty
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      XFER  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [YID_SIZE-1:0] row_lat;
   logic [XID_SIZE-1:0] col_lat;
   logic [LEN_BITS-1:0] rem;
   logic                tmo_hit;
   logic                slot_free;
   logic                cmd_fire;
   logic                src_fire;
   logic                gin_fire;

   assign cmd_fire  = cmd_valid && cmd_ready;
   assign src_fire  = src_valid && src_ready;
   assign gin_fire  = gin_valid && gin_ready;
   assign slot_free = !gin_valid || gin_ready || tmo_hit;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      src_ready = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid && (cmd_len != '0)) state_nxt = XFER;
         end
         XFER: begin
            src_ready = (rem != '0) && slot_free;
            if (src_valid && (rem != '0) && slot_free && (rem == LEN_BITS'(1)))
               state_nxt = DRAIN;
         end
         DRAIN: begin
            if (slot_free) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A new beat takes priority over clearing, so a same-cycle handshake refills without a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_lat     <= '0;
         col_lat     <= '0;
         rem         <= '0;
         gin_valid   <= 1'b0;
         gin_row_tag <= '0;
         gin_col_tag <= '0;
         gin_data    <= '0;
      end else begin
         if (cmd_fire) begin
            row_lat <= cmd_row_tag;
            col_lat <= cmd_col_tag;
            rem     <= cmd_len;
         end
         if (src_fire) begin
            gin_valid   <= 1'b1;
            gin_data    <= src_data;
            gin_row_tag <= row_lat;
            gin_col_tag <= col_lat;
            rem         <= rem - LEN_BITS'(1);
         end else if (gin_fire || tmo_hit) begin
            gin_valid <= 1'b0;
         end
      end
   end

`ifdef GIN_TX_TIMEOUT_EN
   localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [WCW-1:0] wait_cnt;
   logic [15:0]    drop_q;

   assign tmo_hit     = gin_valid && !gin_ready && (wait_cnt == WCW'(TIMEOUT - 1));
   assign timeout_err = tmo_hit;
   assign drop_cnt    = drop_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
         drop_q   <= '0;
      end else begin
         if (src_fire || !gin_valid || gin_ready || tmo_hit) wait_cnt <= '0;
         else                                                wait_cnt <= wait_cnt + WCW'(1);
         if (tmo_hit && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'd1;
      end
   end
`else
   logic unused_timeout_cfg;

   assign tmo_hit            = 1'b0;
   assign timeout_err        = 1'b0;
   assign drop_cnt           = '0;
   assign unused_timeout_cfg = (TIMEOUT == 0);
`endif

endmodule

// File: doc/gin_tag_sender.md
Name: gin_tag_sender

Overview:
- Transmitting end of the global interconnect network (GIN) tag/valid/ready bus.
- Accepts a command (row tag, column tag, beat count) from the global buffer controller, fetches that many data beats from a source stream, and drives each beat onto the GIN bus with the command's tags.
- Downstream multicast controllers compare the tags against their programmed IDs and return ready.
- Holds beats in a single registered output stage, with an optional no-receiver timeout so an unmatched tag cannot deadlock the bus.

Parameters:
- XID_SIZE, `XID_BITS, column tag width.
- YID_SIZE, `YID_BITS, row tag width.
- DATA_SIZE, 32, beat data width.
- LEN_BITS, 8, width of the beat-count field.
- TIMEOUT, 64, stall cycles (gin_valid=1, gin_ready=0) before the current beat is dropped; must be ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_row_tag  in  YID_SIZE  row tag for every beat of the command.
- cmd_col_tag  in  XID_SIZE  column tag for every beat of the command.
- cmd_len  in  LEN_BITS  number of beats; 0 is legal.
- src_valid  in  1  source beat valid.
- src_ready  out  1  source beat taken when src_valid && src_ready.
- src_data  in  DATA_SIZE  source beat payload.
- gin_valid  out  1  beat present on the GIN bus.
- gin_ready  in  1  GIN acceptance (OR of matching receivers' ready).
- gin_row_tag  out  YID_SIZE  registered row tag.
- gin_col_tag  out  XID_SIZE  registered column tag.
- gin_data  out  DATA_SIZE  registered payload.
- busy  out  1  high whenever state is not IDLE.
- timeout_err  out  1  one-cycle pulse when a beat is dropped.
- drop_cnt  out  16  saturating count of dropped beats.

Behaviour:
- Reset (async, immediate): state=IDLE; rem=0; gin_valid=0; gin_row_tag/gin_col_tag/gin_data=0; busy=0; timeout_err=0; drop_cnt=0; wait_cnt=0.
- State IDLE:
  - cmd_ready=1, src_ready=0.
  - On cmd handshake: latch both tags and rem=cmd_len.
  - Next state XFER if cmd_len≠0; otherwise stay in IDLE, with the command consumed and no beat emitted.
- State XFER:
  - cmd_ready=0.
  - slot_free = !gin_valid || gin_ready || tmo_hit.
  - src_ready = (rem≠0) && slot_free.
  - On src handshake: gin_data<=src_data, tags<=latched tags, gin_valid<=1, rem<=rem-1, wait_cnt<=0.
  - When the last beat is fetched (rem goes 1→0), next state is DRAIN.
- State DRAIN:
  - src_ready=0, cmd_ready=0.
  - Go to IDLE in the cycle after the output stage empties (GIN handshake or timeout drop).
- Output stage:
  - A GIN handshake (gin_valid && gin_ready) with no new beat loaded clears gin_valid on the next edge.
  - gin_valid, gin_data and both tags are stable while gin_valid && !gin_ready and no timeout occurs.
  - gin_valid never depends combinationally on gin_ready.
- Throughput and latency:
  - One beat per cycle when gin_ready is held high and src_valid is continuous.
  - Command accepted in cycle N → first src_ready no earlier than N+1 → gin_valid in the cycle after the src handshake.
- Simultaneous events: a GIN handshake in the same cycle as a src handshake replaces the beat with no bubble.
- Timeout:
  - wait_cnt increments each cycle gin_valid && !gin_ready; it resets on a handshake or when a new beat is loaded.
  - tmo_hit = gin_valid && !gin_ready && wait_cnt==TIMEOUT-1.
  - On tmo_hit: the beat is discarded, timeout_err=1 for that cycle, drop_cnt+1 (saturates at 16'hFFFF), and the slot is free that cycle.
- busy = (state≠IDLE).
- Reset mid-transfer: the in-flight beat and remaining count are lost; the bench re-issues the command.

Optional Feature:
- Macro: GIN_TX_TIMEOUT_EN.
- Defined: timeout logic exactly as specified above.
- Undefined:
  - No wait counter.
  - tmo_hit is constant 0.
  - timeout_err and drop_cnt are tied to 0.
  - The sender waits on gin_ready indefinitely.

Test Plan:
- Basic stream: reset; cmd row=2, col=5, len=4; src data 0x10–0x13 continuous; gin_ready=1 → four consecutive gin_valid cycles carrying tags (2,5) and data 0x10–0x13; busy falls the cycle after the last beat; drop_cnt=0.
- Back-pressure: len=3, gin_ready toggling 1,0,0,1,… → gin_data held stable while stalled; beats received in order, each exactly once; src_ready low while the slot is full.
- Zero-length command: cmd len=0 → accepted in one cycle; gin_valid stays 0; the next command is accepted the following cycle.
- Timeout (macro defined, TIMEOUT=4): len=2, gin_ready=0 → timeout_err pulses 4 cycles after gin_valid rises, twice in total; drop_cnt=2; returns to IDLE.
- Timeout disabled (macro undefined): gin_ready=0 for 200 cycles → gin_valid held, timeout_err=0; asserting gin_ready completes the transfer.
- Async reset mid-XFER: assert rst between clock edges during beat 2 of 4 → gin_valid, busy and cmd_ready take reset values immediately; after release, a new len=1 command completes normally.
